cmd_frame_decoder: RTL

Parametrised ground-command decoder for the flight controller. It consumes the byte stream from the UART receiver and parses framed, checksummed packets. It produces N_CH signed setpoints for the attitude/height PID stage, either from preset action codes or directly from the packet payload. It adds inter-byte timeout, frame error reporting and a link-loss failsafe.

---
 rtl/cmd_frame_decoder.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/cmd_frame_decoder.sv
`default_nettype none
// ============================================================================
// cmd_frame_decoder : framed ground-command parser with byte/link watchdogs
// Rev 1.0
// ============================================================================
module cmd_frame_decoder #(
  parameter int         N_CH         = 4,
  parameter int         W            = 24,
  parameter logic [7:0] SOF          = 8'h0A,
  parameter logic [7:0] EOF          = 8'h08,
  parameter int         H_SET        = 32767,
  parameter int         STEP         = 500,
  parameter int         BYTE_TIMEOUT = 50000,
  parameter int         LINK_TIMEOUT = 25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [N_CH*W-1:0] target,
  output logic              target_renew,
  output logic              frame_err,
  output logic              link_lost,
  output logic [7:0]        err_cnt
);

  localparam int NB    = 2 * N_CH;
  localparam int CNT_W = $clog2(NB);
  localparam int BT_W  = $clog2(BYTE_TIMEOUT + 1);
  localparam int LT_W  = $clog2(LINK_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);
  localparam logic [BT_W-1:0]  BT_LAST  = BT_W'(BYTE_TIMEOUT - 1);
  localparam logic [LT_W-1:0]  LT_LAST  = LT_W'(LINK_TIMEOUT - 1);
  localparam logic [7:0]       CMD_PAYLOAD = 8'h10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CHK     = 3'd3;
  localparam logic [2:0] ST_EOF     = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        chk_q, chk_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]        pay_q [NB];
  logic [7:0]        pay_d [NB];
  logic [BT_W-1:0]   byte_timer_q, byte_timer_d;
  logic [LT_W-1:0]   link_timer_q, link_timer_d;
  logic [N_CH*W-1:0] target_q, target_d;
  logic              target_renew_q, target_renew_d;
  logic              frame_err_q, frame_err_d;
  logic              link_lost_q, link_lost_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              w_err;
  logic              w_commit;
  logic              w_byte_tmo;
  logic              w_is_preset;
  logic [N_CH*W-1:0] w_pay_val;
  logic [N_CH*W-1:0] w_frame_val;

  function automatic logic [N_CH*W-1:0] preset_val(input logic [7:0] c);
    logic [N_CH*W-1:0] v;
    logic [W-1:0]      h;
    logic [W-1:0]      s;
    h = W'(H_SET);
    s = W'(STEP);
    v = '0;
    case (c)
      8'h01, 8'h02: v[0 +: W] = h;
      8'h04: begin v[0 +: W] = h; v[W +: W] = s;  end
      8'h05: begin v[0 +: W] = h; v[W +: W] = -s; end
      8'h06: begin v[0 +: W] = h; v[2*W +: W] = s;  end
      8'h07: begin v[0 +: W] = h; v[2*W +: W] = -s; end
      8'h08: begin v[0 +: W] = h; v[3*W +: W] = s;  end
      8'h09: begin v[0 +: W] = h; v[3*W +: W] = -s; end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Little-endian 16-bit payload words, sign-extended to the setpoint width
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign w_pay_val[k*W +: W] = W'($signed({pay_q[2*k+1], pay_q[2*k]}));
  end

  assign w_frame_val = (cmd_q == CMD_PAYLOAD) ? w_pay_val : preset_val(cmd_q);
  assign w_is_preset = (rx_data >= 8'h01) && (rx_data <= 8'h09);
  assign w_byte_tmo  = (state_q != ST_IDLE) && !rx_valid && (byte_timer_q == BT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    w_err    = 1'b0;
    w_commit = 1'b0;
    if (w_byte_tmo) begin
      state_d = ST_IDLE;
      w_err   = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: if (rx_data == SOF) state_d = ST_CMD;
        ST_CMD: begin
          if (w_is_preset)                  state_d = ST_CHK;
          else if (rx_data == CMD_PAYLOAD)  state_d = ST_PAYLOAD;
          else begin
            state_d = ST_IDLE;
            w_err   = 1'b1;
          end
        end
        ST_PAYLOAD: if (byte_cnt_q == CNT_LAST) state_d = ST_CHK;
        ST_CHK: begin
          if (rx_data == chk_q) state_d = ST_EOF;
          else begin
            state_d = ST_IDLE;
            w_err   = 1'b1;
          end
        end
        ST_EOF: begin
          state_d = ST_IDLE;
          if (rx_data == EOF) w_commit = 1'b1;
          else                w_err    = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_d          = cmd_q;
    chk_d          = chk_q;
    byte_cnt_d     = byte_cnt_q;
    pay_d          = pay_q;
    link_timer_d   = link_timer_q;
    link_lost_d    = link_lost_q;
    target_d       = target_q;
    target_renew_d = 1'b0;
    frame_err_d    = w_err;
    err_cnt_d      = err_cnt_q;

    if ((state_d == ST_IDLE) || rx_valid) byte_timer_d = '0;
    else                                  byte_timer_d = byte_timer_q + BT_W'(1);

    if (rx_valid && !w_byte_tmo) begin
      case (state_q)
        ST_CMD: begin
          cmd_d      = rx_data;
          chk_d      = rx_data;
          byte_cnt_d = '0;
        end
        ST_PAYLOAD: begin
          pay_d[byte_cnt_q] = rx_data;
          chk_d             = chk_q ^ rx_data;
          byte_cnt_d        = byte_cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end

    if (w_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;

    // A commit in the watchdog expiry cycle takes priority over failsafe entry
    if (w_commit) begin
      target_d       = w_frame_val;
      target_renew_d = 1'b1;
      link_lost_d    = 1'b0;
      link_timer_d   = '0;
    end else if (!link_lost_q) begin
      if (link_timer_q == LT_LAST) begin
        target_d       = '0;
        target_renew_d = 1'b1;
        link_lost_d    = 1'b1;
        link_timer_d   = '0;
      end else begin
        link_timer_d = link_timer_q + LT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q          <= '0;
      chk_q          <= '0;
      byte_cnt_q     <= '0;
      for (int i = 0; i < NB; i++) pay_q[i] <= '0;
      byte_timer_q   <= '0;
      link_timer_q   <= '0;
      target_q       <= '0;
      target_renew_q <= 1'b0;
      frame_err_q    <= 1'b0;
      link_lost_q    <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      cmd_q          <= cmd_d;
      chk_q          <= chk_d;
      byte_cnt_q     <= byte_cnt_d;
      pay_q          <= pay_d;
      byte_timer_q   <= byte_timer_d;
      link_timer_q   <= link_timer_d;
      target_q       <= target_d;
      target_renew_q <= target_renew_d;
      frame_err_q    <= frame_err_d;
      link_lost_q    <= link_lost_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign target       = target_q;
  assign target_renew = target_renew_q;
  assign frame_err    = frame_err_q;
  assign link_lost    = link_lost_q;
  assign err_cnt      = err_cnt_q;

endmodule
`default_nettype wire
